// File: rtl/l1a_scheduler.sv
// l1a_scheduler
//   Chooses the active L1A source (external fast command or on-chip generator),
//   applies the trigger rules (minimum spacing, max count per sliding window),
//   blocks L1As while the L1 buffer is under back-pressure and keeps the 8-bit
//   L1A counter that goes into frame headers.
//   All state changes on the falling edge of clk; reset is asynchronous, active-low.
//
//   Optional feature: define L1A_SCHED_DROP_STATS_EN to build the 16-bit
//   saturating rejected-L1A counter on dropCount. Without it dropCount is 0.
//
// Ports
//   clk            40 MHz clock (state updates on negedge)
//   reset          asynchronous active-low reset
//   dis            channel disable, forces DISABLED and clears trigger-rule state
//   onChipL1AConf  bit1=1 selects emuL1A, otherwise inL1A
//   inL1A          external L1A request
//   emuL1A         on-chip generator L1A request
//   L1A_Rst        synchronous clear of l1aCount (and dropCount)
//   bufFull        L1 buffer full
//   bufHalfFull    L1 buffer half-full (release threshold of the throttle)
//   l1aOut         accepted L1A, registered single-cycle pulse
//   l1aCount       accepted L1A count, wraps at 256
//   throttled      high while back-pressure holds the scheduler in BUSY
//   dropCount      rejected L1A count (optional feature)
module l1a_scheduler #(
  parameter int WINDOW = 16,
  parameter int MAXN   = 4,
  parameter int MINGAP = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dis,
  input  logic [1:0]  onChipL1AConf,
  input  logic        inL1A,
  input  logic        emuL1A,
  input  logic        L1A_Rst,
  input  logic        bufFull,
  input  logic        bufHalfFull,
  output logic        l1aOut,
  output logic [7:0]  l1aCount,
  output logic        throttled,
  output logic [15:0] dropCount
);

  localparam int WC_W  = $clog2(WINDOW + 1);
  localparam int GAP_W = (MINGAP > 1) ? $clog2(MINGAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MINGAP - 1);
  localparam logic [WC_W-1:0]  WC_MAX   = WC_W'(MAXN);

  typedef enum logic [1:0] {DISABLED, RUN, BUSY} state_t;

  state_t            state_q, state_d;
  // History of accepts from the previous WINDOW-1 cycles; together with the
  // current cycle this spans exactly WINDOW cycles.
  logic [WINDOW-2:0] hist, hist_d;
  logic [WC_W-1:0]   win_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              req_p0, acc_p0, expire_p0;

  // Stage p0: source select and accept decision, all combinational
  always_comb begin
    req_p0    = onChipL1AConf[1] ? emuL1A : inL1A;
    acc_p0    = req_p0 && (state_q == RUN) && !bufFull &&
                (gap_cnt == '0) && (win_cnt < WC_MAX);
    expire_p0 = hist[WINDOW-2];
    hist_d    = hist << 1;
    hist_d[0] = acc_p0;
  end

  always_comb begin
    state_d = state_q;
    if (dis) begin
      state_d = DISABLED;
    end else begin
      case (state_q)
        DISABLED: state_d = RUN;
        RUN:      if (bufFull) state_d = BUSY;
        BUSY:     if (!bufFull && !bufHalfFull) state_d = RUN;
        default:  state_d = DISABLED;
      endcase
    end
  end

  assign throttled = (state_q == BUSY);

  // Stage p1: registered accept, counters and trigger-rule state
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= DISABLED;
      l1aOut   <= 1'b0;
      l1aCount <= 8'd0;
      hist     <= '0;
      win_cnt  <= '0;
      gap_cnt  <= '0;
    end else begin
      state_q <= state_d;
      l1aOut  <= acc_p0;
      // Counter clear wins over a coincident accept; the L1A itself still goes out.
      if (L1A_Rst) l1aCount <= 8'd0;
      else if (acc_p0) l1aCount <= l1aCount + 8'd1;
      if (dis) begin
        hist    <= '0;
        win_cnt <= '0;
        gap_cnt <= '0;
      end else begin
        hist    <= hist_d;
        win_cnt <= win_cnt + WC_W'(acc_p0) - WC_W'(expire_p0);
        if (acc_p0) gap_cnt <= GAP_LOAD;
        else if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

`ifdef L1A_SCHED_DROP_STATS_EN
  logic [15:0] drop_q;
  logic        drop_p0;

  // Requests while DISABLED are ignored rather than counted as drops.
  assign drop_p0 = req_p0 && !acc_p0 && (state_q != DISABLED);

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      drop_q <= 16'd0;
    end else if (L1A_Rst) begin
      drop_q <= 16'd0;
    end else if (drop_p0 && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign dropCount = drop_q;
`else
  assign dropCount = 16'd0;
`endif

endmodule

// File: tb/tb_l1a_scheduler.sv
// Testbench for l1a_scheduler. Inputs are driven right after the rising edge,
// the DUT updates on the falling edge, outputs are sampled at the next rising edge.
// u_dut uses default parameters; u_g1 is the same design with MINGAP=1.
module tb_l1a_scheduler;

`ifdef L1A_SCHED_DROP_STATS_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, dis, inL1A, emuL1A, L1A_Rst, bufFull, bufHalfFull;
  logic [1:0]  conf;
  logic        l1aOut, throttled, g1_out, g1_thr;
  logic [7:0]  l1aCount, g1_cnt;
  logic [15:0] dropCount, g1_drop;

  int n_chk = 0;
  int n_err = 0;

  always #10 clk = ~clk;

  l1a_scheduler u_dut (
    .clk(clk), .reset(reset), .dis(dis), .onChipL1AConf(conf),
    .inL1A(inL1A), .emuL1A(emuL1A), .L1A_Rst(L1A_Rst),
    .bufFull(bufFull), .bufHalfFull(bufHalfFull),
    .l1aOut(l1aOut), .l1aCount(l1aCount), .throttled(throttled),
    .dropCount(dropCount)
  );

  l1a_scheduler #(.WINDOW(16), .MAXN(4), .MINGAP(1)) u_g1 (
    .clk(clk), .reset(reset), .dis(dis), .onChipL1AConf(conf),
    .inL1A(inL1A), .emuL1A(emuL1A), .L1A_Rst(L1A_Rst),
    .bufFull(bufFull), .bufHalfFull(bufHalfFull),
    .l1aOut(g1_out), .l1aCount(g1_cnt), .throttled(g1_thr),
    .dropCount(g1_drop)
  );

  typedef struct {
    logic       dis;
    logic [1:0] conf;
    logic       inl, emu, lrst, full, half;
    logic       eout, ethr;
    logic [7:0] ecnt;
    logic [15:0] edrop;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic d, logic [1:0] c, logic i, logic e, logic r,
                              logic f, logic h, logic eo, logic et,
                              logic [7:0] ec, logic [15:0] ed);
    vec_t v;
    v.dis = d; v.conf = c; v.inl = i; v.emu = e; v.lrst = r;
    v.full = f; v.half = h; v.eout = eo; v.ethr = et; v.ecnt = ec; v.edrop = ed;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic d, input logic [1:0] c, input logic i, input logic e,
                       input logic r, input logic f, input logic h);
    dis = d; conf = c; inL1A = i; emuL1A = e; L1A_Rst = r; bufFull = f; bufHalfFull = h;
  endtask

  task automatic tick();
    @(posedge clk);
  endtask

  // Disable for a cycle (clears trigger-rule state), then re-enable with a
  // counter clear; the next cycle runs in RUN with empty history.
  task automatic setup();
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
  endtask

  initial begin
    int pulses;
    logic [15:0] d_exp;

    // c0..c15: spacing, gap violation, window limit, counter clear
    add(0,0,0,0,0,0,0, 0,0,0,0);
    add(0,0,0,0,0,0,0, 0,0,0,0);
    add(0,0,1,0,0,0,0, 1,0,1,0);
    add(0,0,0,0,0,0,0, 0,0,1,0);
    add(0,0,1,0,0,0,0, 1,0,2,0);
    add(0,0,0,0,0,0,0, 0,0,2,0);
    add(0,0,0,0,0,0,0, 0,0,2,0);
    add(0,0,1,0,0,0,0, 1,0,3,0);
    add(0,0,1,0,0,0,0, 0,0,3,1);
    add(0,0,0,0,0,0,0, 0,0,3,1);
    add(0,0,1,0,0,0,0, 1,0,4,1);
    add(0,0,0,0,0,0,0, 0,0,4,1);
    add(0,0,1,0,0,0,0, 0,0,4,2);
    add(0,0,0,0,0,0,0, 0,0,4,2);
    add(0,0,0,0,1,0,0, 0,0,0,0);
    add(0,0,0,0,0,0,0, 0,0,0,0);
    // t0..t15: back-pressure with hysteresis
    for (int k = 0; k < 5; k++) add(0,0,0,0,0,0,0, 0,0,0,0);
    add(0,0,1,0,0,1,1, 0,1,0,1);
    add(0,0,0,0,0,1,1, 0,1,0,1);
    add(0,0,0,0,0,1,1, 0,1,0,1);
    add(0,0,0,0,0,0,1, 0,1,0,1);
    add(0,0,0,0,0,0,1, 0,1,0,1);
    add(0,0,1,0,0,0,1, 0,1,0,2);
    add(0,0,0,0,0,0,1, 0,1,0,2);
    add(0,0,0,0,0,0,0, 0,0,0,2);
    add(0,0,0,0,0,0,0, 0,0,0,2);
    add(0,2'b01,1,0,0,0,0, 1,0,1,2);
    add(0,0,0,0,0,0,0, 0,0,1,2);

    // Reset state
    reset = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_l1aOut", 32'(l1aOut), 32'd0);
    chk("rst_l1aCount", 32'(l1aCount), 32'd0);
    chk("rst_throttled", 32'(throttled), 32'd0);
    chk("rst_dropCount", 32'(dropCount), 32'd0);
    @(posedge clk);
    reset = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].dis, tbl[i].conf, tbl[i].inl, tbl[i].emu, tbl[i].lrst,
            tbl[i].full, tbl[i].half);
      tick();
      d_exp = DROP_EN ? tbl[i].edrop : 16'd0;
      chk($sformatf("vec%0d_l1aOut", i), 32'(l1aOut), 32'(tbl[i].eout));
      chk($sformatf("vec%0d_throttled", i), 32'(throttled), 32'(tbl[i].ethr));
      chk($sformatf("vec%0d_l1aCount", i), 32'(l1aCount), 32'(tbl[i].ecnt));
      chk($sformatf("vec%0d_dropCount", i), 32'(dropCount), 32'(d_exp));
    end

    // Request held high 20 cycles: MINGAP=1 accepts 0-3,16-19; MINGAP=2 accepts 0,2,4,6,16,18
    setup();
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk($sformatf("burst%0d_g1_out", k), 32'(g1_out), 32'((k < 4) || (k >= 16)));
      chk($sformatf("burst%0d_out", k), 32'(l1aOut),
          32'((k == 0) || (k == 2) || (k == 4) || (k == 6) || (k == 16) || (k == 18)));
    end
    chk("burst_g1_cnt", 32'(g1_cnt), 32'd8);
    chk("burst_g1_drop", 32'(g1_drop), DROP_EN ? 32'd12 : 32'd0);
    chk("burst_g1_thr", 32'(g1_thr), 32'd0);
    chk("burst_cnt", 32'(l1aCount), 32'd6);
    chk("burst_drop", 32'(dropCount), DROP_EN ? 32'd14 : 32'd0);

    // 256 L1As spaced 4 cycles: counter wraps to 0
    setup();
    pulses = 0;
    for (int k = 0; k < 256; k++) begin
      drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      pulses += int'(l1aOut);
      if (k == 254) chk("wrap_cnt255", 32'(l1aCount), 32'd255);
      drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int j = 0; j < 3; j++) begin
        tick();
        pulses += int'(l1aOut);
      end
    end
    chk("wrap_pulses", 32'(pulses), 32'd256);
    chk("wrap_cnt0", 32'(l1aCount), 32'd0);

    // L1A_Rst coincident with an accepted L1A
    drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("pre_rst_cnt", 32'(l1aCount), 32'd1);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) tick();
    drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    chk("rst_acc_out", 32'(l1aOut), 32'd1);
    chk("rst_acc_cnt", 32'(l1aCount), 32'd0);

    // On-chip source selected: only emuL1A pulses are taken; emu at 1 violates the gap
    setup();
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      inL1A  = (k == 2) || (k == 6);
      emuL1A = (k == 0) || (k == 1) || (k == 4);
      tick();
      chk($sformatf("src%0d_out", k), 32'(l1aOut), 32'((k == 0) || (k == 4)));
    end
    chk("src_cnt", 32'(l1aCount), 32'd2);
    chk("src_drop", 32'(dropCount), DROP_EN ? 32'd1 : 32'd0);

    // Disabled: requests ignored, counters frozen
    drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk($sformatf("dis%0d_out", k), 32'(l1aOut), 32'd0);
    end
    chk("dis_cnt", 32'(l1aCount), 32'd2);
    chk("dis_drop", 32'(dropCount), DROP_EN ? 32'd1 : 32'd0);
    chk("dis_thr", 32'(throttled), 32'd0);

    // Asynchronous reset between clock edges
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #5 reset = 1'b0;
    #1;
    chk("arst_cnt", 32'(l1aCount), 32'd0);
    chk("arst_drop", 32'(dropCount), 32'd0);
    chk("arst_out", 32'(l1aOut), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
